// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: start bit, DATA_W data bits LSB first, stop bit.
// Completed words are held on dout with a valid/ack handshake; framing errors and overruns pulse.
module serial_deser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  input  logic              dack,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr;
  logic              load;

  assign load = ce && (state == STOP) && din;

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        IDLE:    if (!din) state_nxt = DATA;
        DATA:    if (cnt == CW'(DATA_W - 1)) state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      dout      <= '0;
      dvalid    <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (ce) begin
        case (state)
          IDLE: if (!din) cnt <= '0;
          DATA: begin
            // Right shift: the first (LSB) bit ends up at bit 0 after DATA_W shifts.
            sr  <= {din, sr[DATA_W-1:1]};
            cnt <= cnt + 1'b1;
          end
          STOP: if (!din) frame_err <= 1'b1;
          default: ;
        endcase
      end
      if (load) begin
        dout    <= sr;
        dvalid  <= 1'b1;
        overrun <= dvalid && !dack;
      end else if (dack && dvalid) begin
        dvalid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/serial_deser.md
# serial_deser

Serial-to-parallel deserializer fed directly by the two-flop bit pipeline (`b -> a -> c`): its `din` input is the pipeline's final-stage output. It frames the serial stream as start bit, `DATA_W` data bits (LSB first), and a stop bit. Each completed byte is presented on a held parallel bus with a valid/ack handshake. Framing errors and overruns are flagged.

## Interface
- `DATA_W`, default 8, number of data bits per frame (2..16).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `ce`  input  1  bit-enable; one serial bit is sampled per rising edge with `ce`=1.
- `din`  input  1  serial bit from upstream pipeline output.
- `dout`  output  DATA_W  last good received word; held until replaced.
- `dvalid`  output  1  `dout` holds an unacknowledged word.
- `dack`  input  1  consumer acknowledge; clears `dvalid`.
- `busy`  output  1  high while in START-done/DATA/STOP (frame in progress).
- `frame_err`  output  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  output  1  one-cycle pulse: new word loaded while previous unacknowledged.

## Operation
- Reset values: `dout`=0, `dvalid`=0, `busy`=0, `frame_err`=0, `overrun`=0, state IDLE, bit counter 0, shift register 0.
- FSM states: IDLE, DATA, STOP. All transitions occur only on edges with `ce`=1. With `ce`=0, state, counter and shift register hold, and `frame_err`/`overrun` return to 0.
- IDLE: `ce`=1 and `din`=0 -> start bit accepted. Go to DATA with counter=0. `din`=1 -> stay.
- DATA: each `ce`=1 edge shifts `din` in at the MSB side (right shift, LSB first on the line) and increments the counter. After the `DATA_W`-th bit -> STOP.
- STOP, `ce`=1, `din`=1: load `dout` with the shift register, set `dvalid`=1 -> IDLE. If `dvalid` was 1 and `dack`=0 on that edge, pulse `overrun`. The new word still overwrites.
- STOP, `ce`=1, `din`=0: pulse `frame_err`, discard word, leave `dout`/`dvalid` unchanged -> IDLE. The zero stop bit is not reused as a start bit.
- `dack`=1 with `dvalid`=1 and no load on that edge -> `dvalid`=0 next edge. `dack` with `dvalid`=0 is ignored.
- Simultaneous load and `dack`: load wins. `dvalid` stays 1 with the new word, no `overrun`.
- `busy` = (state != IDLE), registered with the state.
- Width: counter is `$clog2(DATA_W+1)` bits; no wrap beyond `DATA_W`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Start bit sampled at edge E0 -> `busy`=1 after E0.
- Data bits are sampled at the next `DATA_W` `ce`-edges and the stop bit at the following `ce`-edge Es. With `ce` held high, Es = E0 + `DATA_W` + 1 cycles.
- `dout`/`dvalid` update after Es. `frame_err`/`overrun` are high for exactly the cycle after Es. `busy`=0 after Es.
- The next start bit can be accepted on the first `ce`-edge after Es: back-to-back frames with no idle bit.
- `rst` asserted at any time (including mid-frame or during a `dvalid`/`dack` exchange) immediately forces all reset values. The partial frame is discarded. The first edge after release samples in IDLE.
- Upstream alignment: `din` is already two flops behind the source bit. This block adds no further sampling stage.

## Test plan
- Nominal frame, `ce`=1 constant, line 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop) -> `dvalid`=1 and `dout`=8'hA5 one cycle after the stop edge. `dack` pulse -> `dvalid`=0 next edge.
- Bad stop bit: 0x3C framed with stop=0 -> `frame_err` high one cycle, `dout`/`dvalid` unchanged, `busy`=0. A subsequent good 0x81 frame is received correctly.
- Overrun: receive 0x11, no `dack`, then receive 0x22 -> `overrun` pulse, `dout`=8'h22, `dvalid`=1. Repeat with `dack`=1 on the load edge -> no `overrun`, `dvalid`=1, `dout`=new word.
- `ce` gaps: 0x5A sent with `ce` toggling 1,0,0,1 per bit and `din` glitching while `ce`=0 -> `dout`=8'h5A, glitches ignored.
- Reset mid-frame: assert `rst` asynchronously (between edges) after 4 data bits of 0xFF with `dvalid`=1 -> all outputs 0 immediately. After release, a 0x0F frame yields `dout`=8'h0F.
- Back-to-back: 0xC3 then 0x3C with no idle bits, `dack` each word -> two `dvalid` assertions exactly `DATA_W`+2 cycles apart, both values correct.
